// File: rtl/golden_dispatch_if.sv
// golden_dispatch_if: shipment request, stage inputs and receiver drive/status signals.
`default_nettype none

interface golden_dispatch_if #(
    parameter int CNT_W = 8
) ();
    logic             ship_req;
    logic             ship_ready;
    logic             customs_ok;
    logic             transit_slot;
    logic             truck_arrive;
    logic             delivery_confirmed;
    logic             customs_cleared;
    logic             transit_ready;
    logic             arrived_on_truck;
    logic             ship_done;
    logic             ship_fail;
    logic [CNT_W-1:0] ship_count;

    modport master (
        output ship_req, customs_ok, transit_slot, truck_arrive, delivery_confirmed,
        input  ship_ready, customs_cleared, transit_ready, arrived_on_truck,
               ship_done, ship_fail, ship_count
    );

    modport slave (
        input  ship_req, customs_ok, transit_slot, truck_arrive, delivery_confirmed,
        output ship_ready, customs_cleared, transit_ready, arrived_on_truck,
               ship_done, ship_fail, ship_count
    );
endinterface

`default_nettype wire

// File: rtl/golden_dispatch.sv
// golden_dispatch: staged shipment FSM with per-stage timeout and delivery counter.
// Optional GOLDEN_DISPATCH_RETRY_EN: first timeout of a shipment restarts at CUSTOMS.
`default_nettype none

module golden_dispatch #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    golden_dispatch_if.slave  dsp
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CUSTOMS = 3'd1,
        S_TRANSIT = 3'd2,
        S_TRUCK   = 3'd3,
        S_CONFIRM = 3'd4,
        S_END     = 3'd5
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t           state_q;
    logic [7:0]       timer_q;
    logic             ready_q;
    logic             cleared_q;
    logic             transit_q;
    logic             arrived_q;
    logic             done_q;
    logic             fail_q;
    logic [CNT_W-1:0] count_q;
`ifdef GOLDEN_DISPATCH_RETRY_EN
    logic             retry_q;
`endif

    logic exit_d;
    logic expired_d;

    always_comb begin
        exit_d = 1'b0;
        case (state_q)
            S_CUSTOMS: exit_d = dsp.customs_ok;
            S_TRANSIT: exit_d = dsp.transit_slot;
            S_TRUCK:   exit_d = dsp.truck_arrive;
            S_CONFIRM: exit_d = dsp.delivery_confirmed;
            default:   exit_d = 1'b0;
        endcase
        expired_d = (timer_q == TIMER_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            timer_q   <= 8'd0;
            ready_q   <= 1'b1;
            cleared_q <= 1'b0;
            transit_q <= 1'b0;
            arrived_q <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            count_q   <= '0;
`ifdef GOLDEN_DISPATCH_RETRY_EN
            retry_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            fail_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (dsp.ship_req) begin
                        state_q <= S_CUSTOMS;
                        timer_q <= 8'd0;
                        ready_q <= 1'b0;
`ifdef GOLDEN_DISPATCH_RETRY_EN
                        retry_q <= 1'b0;
`endif
                    end
                end
                S_CUSTOMS, S_TRANSIT, S_TRUCK, S_CONFIRM: begin
                    // Exit condition wins over a simultaneous timeout.
                    if (exit_d) begin
                        timer_q <= 8'd0;
                        case (state_q)
                            S_CUSTOMS: begin
                                state_q   <= S_TRANSIT;
                                cleared_q <= 1'b1;
                            end
                            S_TRANSIT: begin
                                state_q   <= S_TRUCK;
                                transit_q <= 1'b1;
                            end
                            S_TRUCK: begin
                                state_q   <= S_CONFIRM;
                                arrived_q <= 1'b1;
                            end
                            default: begin
                                state_q   <= S_END;
                                done_q    <= 1'b1;
                                count_q   <= count_q + 1'b1;
                                cleared_q <= 1'b0;
                                transit_q <= 1'b0;
                                arrived_q <= 1'b0;
                            end
                        endcase
                    end else if (expired_d) begin
                        timer_q   <= 8'd0;
                        cleared_q <= 1'b0;
                        transit_q <= 1'b0;
                        arrived_q <= 1'b0;
`ifdef GOLDEN_DISPATCH_RETRY_EN
                        if (!retry_q) begin
                            retry_q <= 1'b1;
                            state_q <= S_CUSTOMS;
                        end else begin
                            state_q <= S_END;
                            fail_q  <= 1'b1;
                        end
`else
                        state_q <= S_END;
                        fail_q  <= 1'b1;
`endif
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                S_END: begin
                    state_q   <= S_IDLE;
                    ready_q   <= 1'b1;
                    timer_q   <= 8'd0;
                    cleared_q <= 1'b0;
                    transit_q <= 1'b0;
                    arrived_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    timer_q <= 8'd0;
                end
            endcase
        end
    end

    assign dsp.ship_ready       = ready_q;
    assign dsp.customs_cleared  = cleared_q;
    assign dsp.transit_ready    = transit_q;
    assign dsp.arrived_on_truck = arrived_q;
    assign dsp.ship_done        = done_q;
    assign dsp.ship_fail        = fail_q;
    assign dsp.ship_count       = count_q;
endmodule

`default_nettype wire

// File: tb/tb_golden_dispatch.sv
// tb_golden_dispatch: randomized shipments checked cycle by cycle against a per-shipment schedule model.
`default_nettype none

module tb_golden_dispatch;
    localparam int T  = 4;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    golden_dispatch_if #(.CNT_W(CW)) dsp ();

    golden_dispatch #(.TIMEOUT(T), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dsp   (dsp)
    );

    // stage: 0 idle, 1 customs, 2 transit, 3 truck, 4 confirm, 5 end
    typedef struct {
        int          stage;
        bit          in_hi;
        bit          rdy, cc, tr, ar, done, fail;
        logic [CW-1:0] cnt;
    } cyc_t;

    cyc_t          sched[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [CW-1:0] cnt_m   = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic cyc_t mk(int stage, bit in_hi, bit rdy, bit cc, bit tr, bit ar,
                                bit done, bit fail);
        cyc_t c;
        c.stage = stage; c.in_hi = in_hi; c.rdy = rdy;
        c.cc = cc; c.tr = tr; c.ar = ar; c.done = done; c.fail = fail;
        c.cnt = cnt_m;
        return c;
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check_outs(input cyc_t c);
        chk($sformatf("ship_ready st%0d", c.stage), 32'(dsp.ship_ready), 32'(c.rdy));
        chk($sformatf("customs_cleared st%0d", c.stage), 32'(dsp.customs_cleared), 32'(c.cc));
        chk($sformatf("transit_ready st%0d", c.stage), 32'(dsp.transit_ready), 32'(c.tr));
        chk($sformatf("arrived_on_truck st%0d", c.stage), 32'(dsp.arrived_on_truck), 32'(c.ar));
        chk($sformatf("ship_done st%0d", c.stage), 32'(dsp.ship_done), 32'(c.done));
        chk($sformatf("ship_fail st%0d", c.stage), 32'(dsp.ship_fail), 32'(c.fail));
        chk($sformatf("ship_count st%0d", c.stage), 32'(dsp.ship_count), 32'(c.cnt));
    endtask

    // Drive one cycle: the consuming input follows the schedule, every other input is noise.
    task automatic run_cycle(input cyc_t c);
        @(posedge clk);
        #1;
        dsp.ship_req           = (c.stage == 0) ? c.in_hi : rb();
        dsp.customs_ok         = (c.stage == 1) ? c.in_hi : rb();
        dsp.transit_slot       = (c.stage == 2) ? c.in_hi : rb();
        dsp.truck_arrive       = (c.stage == 3) ? c.in_hi : rb();
        dsp.delivery_confirmed = (c.stage == 4) ? c.in_hi : rb();
        @(negedge clk);
        check_outs(c);
    endtask

    // One shipment: each stage exits in its cycle d (d >= T means it never exits).
    task automatic build_ship(input bit rnd, input int dfix);
        int k;
        int d;
        int gap;
        bit retried;
        sched.push_back(mk(0, 1'b1, 1'b1, 0, 0, 0, 0, 0));
        k = 1;
        retried = 1'b0;
        while (k >= 1 && k <= 4) begin
            d = rnd ? int'($urandom_range(0, T)) : dfix;
            for (int j = 0; j < T; j++) begin
                sched.push_back(mk(k, (j == d), 1'b0, (k >= 2), (k >= 3), (k >= 4), 0, 0));
                if (j == d) begin
                    k++;
                    break;
                end
                if (j == T - 1) begin
`ifdef GOLDEN_DISPATCH_RETRY_EN
                    if (!retried) begin
                        retried = 1'b1;
                        k = 1;
                    end else begin
                        k = -1;
                    end
`else
                    k = -1;
`endif
                end
            end
        end
        if (k == 5) begin
            cnt_m = cnt_m + 1'b1;
            sched.push_back(mk(5, 1'b0, 1'b0, 0, 0, 0, 1, 0));
        end else begin
            sched.push_back(mk(5, 1'b0, 1'b0, 0, 0, 0, 0, 1));
        end
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++)
            sched.push_back(mk(0, 1'b0, 1'b1, 0, 0, 0, 0, 0));
    endtask

    task automatic run_sched();
        while (sched.size() > 0)
            run_cycle(sched.pop_front());
    endtask

    initial begin
        cyc_t c;
        dsp.ship_req = 1'b0;
        dsp.customs_ok = 1'b0;
        dsp.transit_slot = 1'b0;
        dsp.truck_arrive = 1'b0;
        dsp.delivery_confirmed = 1'b0;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_outs(mk(0, 1'b0, 1'b1, 0, 0, 0, 0, 0));

        // Directed: every stage in one cycle, every stage timing out, exits on the last timer cycle.
        build_ship(1'b0, 0);
        build_ship(1'b0, T);
        build_ship(1'b0, T - 1);
        build_ship(1'b0, 0);
        run_sched();

        for (int s = 0; s < 40; s++) begin
            build_ship(1'b1, 0);
            run_sched();
        end

        // Reset while in TRUCK: silent abort, counter cleared.
        sched.push_back(mk(0, 1'b1, 1'b1, 0, 0, 0, 0, 0));
        sched.push_back(mk(1, 1'b1, 1'b0, 0, 0, 0, 0, 0));
        sched.push_back(mk(2, 1'b1, 1'b0, 1, 0, 0, 0, 0));
        run_sched();
        @(posedge clk);
        #1;
        dsp.ship_req = 1'b0;
        dsp.truck_arrive = 1'b0;
        dsp.delivery_confirmed = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_outs(mk(3, 1'b0, 1'b0, 1, 1, 0, 0, 0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        cnt_m = '0;
        @(negedge clk);
        c = mk(0, 1'b0, 1'b1, 0, 0, 0, 0, 0);
        check_outs(c);

        build_ship(1'b0, 0);
        run_sched();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
